smachine_io_port: RTL



---
 rtl/smachine_io_pkg.sv | 16 +
 rtl/smachine_debounce.sv | 53 +++++
 rtl/smachine_io_port.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/smachine_io_pkg.sv
// Shared constants for the S-Machine switch/LED port: register offsets and default bus width.
package smachine_io_pkg;

  localparam int unsigned IO_DATA_W = 8;

  localparam logic [1:0] IO_SW_STATE   = 2'd0;
  localparam logic [1:0] IO_SW_EVENT   = 2'd1;
  localparam logic [1:0] IO_LED_OUT    = 2'd2;
  localparam logic [1:0] IO_LED_TOGGLE = 2'd3;

  // The window is four registers wide, so only the upper six address bits select it.
  function automatic logic io_in_window(input logic [7:0] addr, input logic [7:0] base);
    return addr[7:2] == base[7:2];
  endfunction

endpackage

// File: rtl/smachine_debounce.sv
// One switch channel: 2-flop synchroniser, stability counter, debounced level and rise pulse.
module smachine_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_enable,
  input  logic i_sw,
  output logic o_level,
  output logic o_rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differ;
  logic             w_expire;

  assign w_differ = r_sync != r_level;
  assign w_expire = i_enable && w_differ && (r_cnt == CNT_MAX);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta <= i_sw;
      r_sync <= r_meta;
      // Synchroniser free-runs; the debounce state freezes while disabled.
      if (i_enable) begin
        if (!w_differ) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
          r_level <= r_sync;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_level = r_level;
  // Combinational so the event flag sets on the same edge as the level changes.
  assign o_rise  = w_expire && r_sync;

endmodule

// File: rtl/smachine_io_port.sv
// Memory-mapped switch/LED port for the S-Machine CPU with a 4-register bus window.
// Optional interrupt and IRQ_MASK register are enabled by defining SMACHINE_IO_IRQ_EN.
module smachine_io_port
  import smachine_io_pkg::*;
#(
  parameter int unsigned N_SW         = 2,
  parameter int unsigned N_LED        = 2,
  parameter int unsigned DATA_W       = IO_DATA_W,
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter logic [7:0]  BASE_ADDR    = 8'hF0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [7:0]        addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wr,
  input  logic              rd,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  input  logic [N_SW-1:0]   switch,
  output logic [N_LED-1:0]  led
`ifdef SMACHINE_IO_IRQ_EN
  ,
  output logic              irq
`endif
);

  if (N_SW < 1 || N_SW > DATA_W) begin : g_bad_n_sw
    $error("N_SW must be in 1..DATA_W");
  end
  if (N_LED < 1 || N_LED > DATA_W) begin : g_bad_n_led
    $error("N_LED must be in 1..DATA_W");
  end
  if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYC must be at least 2");
  end
  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
    $error("BASE_ADDR must be 4-register aligned");
  end

  logic [N_SW-1:0]   w_level;
  logic [N_SW-1:0]   w_rise;
  logic              w_hit;
  logic              w_wr;
  logic              w_rd;
  logic [1:0]        w_off;
  logic [N_SW-1:0]   w_clr;
  logic [N_SW-1:0]   w_event_d;
  logic [DATA_W-1:0] w_rd_val;
  logic              w_unused;

  logic [DATA_W-1:0] r_rdata;
  logic              r_ack;
  logic [N_LED-1:0]  r_led;
  logic [N_SW-1:0]   r_event;
`ifdef SMACHINE_IO_IRQ_EN
  logic [N_SW-1:0]   r_mask;
  logic              r_irq;
  logic              w_mask_wr;
`endif

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    smachine_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
      .i_clk    (clk),
      .i_reset_n(reset_n),
      .i_enable (enable),
      .i_sw     (switch[i]),
      .o_level  (w_level[i]),
      .o_rise   (w_rise[i])
    );
  end

  // A simultaneous wr/rd is a write; a disabled block ignores the bus entirely.
  assign w_hit = enable && io_in_window(addr, BASE_ADDR);
  assign w_wr  = w_hit && wr;
  assign w_rd  = w_hit && rd && !wr;
  assign w_off = addr[1:0];

  assign w_clr     = (w_wr && w_off == IO_SW_EVENT) ? wdata[N_SW-1:0] : '0;
  // Set wins over a same-cycle W1C on the same bit.
  assign w_event_d = (r_event & ~w_clr) | w_rise;

`ifdef SMACHINE_IO_IRQ_EN
  assign w_mask_wr = w_wr && w_off == IO_LED_TOGGLE && wdata[DATA_W-1];
`endif

  always_comb begin
    w_rd_val = '0;
    unique case (w_off)
      IO_SW_STATE:   w_rd_val[N_SW-1:0]  = w_level;
      IO_SW_EVENT:   w_rd_val[N_SW-1:0]  = r_event;
      IO_LED_OUT:    w_rd_val[N_LED-1:0] = r_led;
      IO_LED_TOGGLE: begin
`ifdef SMACHINE_IO_IRQ_EN
        w_rd_val[N_SW-1:0] = r_mask;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_led   <= '0;
      r_event <= '0;
    end else begin
      r_ack   <= w_wr || w_rd;
      r_event <= w_event_d;
      if (w_rd) begin
        r_rdata <= w_rd_val;
      end
      if (w_wr) begin
        unique case (w_off)
          IO_LED_OUT: r_led <= wdata[N_LED-1:0];
          IO_LED_TOGGLE: begin
`ifdef SMACHINE_IO_IRQ_EN
            if (!wdata[DATA_W-1]) begin
              r_led <= r_led ^ wdata[N_LED-1:0];
            end
`else
            r_led <= r_led ^ wdata[N_LED-1:0];
`endif
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SMACHINE_IO_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '0;
      r_irq  <= 1'b0;
    end else begin
      if (w_mask_wr) begin
        r_mask <= wdata[N_SW-1:0];
      end
      r_irq <= |(r_event & r_mask);
    end
  end

  assign irq = r_irq;
`endif

  assign rdata = r_rdata;
  assign ack   = r_ack;
  assign led   = r_led;

  // Data bits above the implemented widths are intentionally ignored.
  assign w_unused = ^wdata;

endmodule
